// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared defaults and types for the gated-window frequency meter
package freq_meter_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int HZ_W_DEFAULT   = 28;

  typedef logic [27:0] hz_t;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer plus rising-edge detector for an async pin
module edge_sync
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_s_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic synced;
  logic delayed;

  // Two synchronizer stages, then one delay flop so the edge can be seen as synced & ~delayed
  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      meta    <= 1'b0;
      synced  <= 1'b0;
      delayed <= 1'b0;
    end else begin
      meta    <= async_in;
      synced  <= meta;
      delayed <= synced;
    end
  end

  assign rise = synced & ~delayed;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts input rising edges over a fixed clock gate and holds the result
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int HZ_W        = HZ_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_s_n,
  input  logic            sample_signal,
  output logic [HZ_W-1:0] hz
);

  localparam int              GW       = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]   GATE_END = GW'(GATE_CYCLES - 1);
  localparam logic [HZ_W-1:0] HZ_MAX   = '1;

  logic            rise;
  logic [GW-1:0]   gate_cnt;
  logic            gate_end;
  logic [HZ_W-1:0] edge_cnt;
  logic [HZ_W-1:0] edge_next;

  edge_sync u_edge_sync (
    .clk      (clk),
    .rst_s_n  (rst_s_n),
    .async_in (sample_signal),
    .rise     (rise)
  );

  assign gate_end = (gate_cnt == GATE_END);

  // Edge count including the current cycle's rise, held at full scale instead of wrapping
  always_comb begin
    edge_next = edge_cnt;
    if (rise && (edge_cnt != HZ_MAX)) begin
      edge_next = edge_cnt + 1'b1;
    end
  end

  // Gate timer: free-running 0..GATE_CYCLES-1 so windows are back to back
  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      gate_cnt <= '0;
    end else if (gate_end) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
    end
  end

  // Edge accumulator and result register; a rise on the closing cycle belongs to the closing gate
  always_ff @(posedge clk) begin
    if (!rst_s_n) begin
      edge_cnt <= '0;
      hz       <= '0;
    end else if (gate_end) begin
      edge_cnt <= '0;
      hz       <= edge_next;
    end else begin
      edge_cnt <= edge_next;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter with a wide and a 4-bit saturating instance
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int GATE = 100;

  typedef struct packed {
    hz_t        a;
    logic [3:0] b;
    logic [7:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_s_n = 1'b0;
  logic       sample_signal = 1'b0;
  hz_t        hz_a;
  logic [3:0] hz_b;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   gcnt = 0;
  bit   in_rst = 1'b0;
  bit   rst_evt = 1'b0;
  bit   gate_evt = 1'b0;
  hz_t        last_a = '0;
  logic [3:0] last_b = '0;

  freq_meter #(.CLK_HZ(50_000_000), .GATE_CYCLES(GATE), .HZ_W(28)) dut_a (
    .clk           (clk),
    .rst_s_n       (rst_s_n),
    .sample_signal (sample_signal),
    .hz            (hz_a)
  );

  freq_meter #(.CLK_HZ(50_000_000), .GATE_CYCLES(GATE), .HZ_W(4)) dut_b (
    .clk           (clk),
    .rst_s_n       (rst_s_n),
    .sample_signal (sample_signal),
    .hz            (hz_b)
  );

  always #5 clk = ~clk;

  // Bench-side gate tracker: flags the edge where a result is due, or a reset edge
  always @(posedge clk) begin
    if (!rst_s_n) begin
      gcnt = 0;
      if (!in_rst) rst_evt = 1'b1;
      in_rst = 1'b1;
    end else begin
      in_rst = 1'b0;
      gcnt = gcnt + 1;
      if (gcnt == GATE) begin
        gcnt = 0;
        gate_evt = 1'b1;
      end
    end
  end

  // Monitor: pop and compare on due edges, check hold in mid-gate
  always @(negedge clk) begin
    if (rst_evt || gate_evt) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: result presented with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (hz_a !== e.a) begin
          errors++;
          $display("FAIL hz_wide[id %0d]: got %0d expected %0d", e.id, hz_a, e.a);
        end
        checks++;
        if (hz_b !== e.b) begin
          errors++;
          $display("FAIL hz_sat4[id %0d]: got %0d expected %0d", e.id, hz_b, e.b);
        end
        last_a = e.a;
        last_b = e.b;
      end
      rst_evt  = 1'b0;
      gate_evt = 1'b0;
    end else if (!in_rst && gcnt == GATE / 2) begin
      checks++;
      if (hz_a !== last_a || hz_b !== last_b) begin
        errors++;
        $display("FAIL hold_mid_gate: got %0d/%0d expected %0d/%0d", hz_a, hz_b, last_a, last_b);
      end
    end
  end

  task automatic push(input hz_t a, input logic [3:0] b, input int id);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.id = 8'(id);
    sb.push_back(e);
  endtask

  // One gate of stimulus: high when c >= start and (c % per) < hi
  task automatic run_gate(input int per, input int hi, input int start,
                          input hz_t ea, input logic [3:0] eb, input int id);
    push(ea, eb, id);
    for (int c = 0; c < GATE; c++) begin
      @(negedge clk);
      rst_s_n = 1'b1;
      sample_signal = (c >= start) && ((c % per) < hi);
    end
  endtask

  initial begin
    push(0, 0, 0);
    repeat (3) @(negedge clk);

    run_gate(10,  5,   0, 10, 10,  1);
    run_gate(10,  5,   0, 10, 10,  2);
    run_gate( 4,  2,   0, 25, 15,  3);
    run_gate( 5,  2,   0, 20, 15,  4);
    run_gate( 1,  1,   0,  1,  1,  5);
    run_gate( 1,  1,   0,  0,  0,  6);
    run_gate( 1,  1, 100,  0,  0,  7);
    run_gate( 1,  1,  97,  1,  1,  8);
    run_gate( 1,  1, 100,  0,  0,  9);
    run_gate( 1,  1,  98,  0,  0, 10);
    run_gate( 1,  1, 100,  1,  1, 11);
    run_gate( 4,  2,   0, 25, 15, 12);

    // Seven edges, then a one-clock reset at cycle 50 of the gate
    for (int c = 0; c < 49; c++) begin
      @(negedge clk);
      rst_s_n = 1'b1;
      sample_signal = (c < 39) && ((c % 6) < 3);
    end
    push(0, 0, 13);
    @(negedge clk);
    rst_s_n = 1'b0;
    sample_signal = 1'b0;

    run_gate(10,  5,   0, 10, 10, 14);
    run_gate(20, 10,   0,  5,  5, 15);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within 100000 ns");
    $fatal(1);
  end

endmodule
